// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: condition-code encoding and flag bit positions shared by the condition unit.
package cond_unit_pkg;
  typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition-code evaluation against a {N,Z,C,V} flag set.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];
  always_comb begin
    case (cond_e'(cond))
      EQ:      pass = z;
      NE:      pass = ~z;
      CS:      pass = c;
      CC:      pass = ~c;
      MI:      pass = n;
      PL:      pass = ~n;
      VS:      pass = v;
      VC:      pass = ~v;
      HI:      pass = c & ~z;
      LS:      pass = ~c | z;
      GE:      pass = n == v;
      LT:      pass = n != v;
      GT:      pass = ~z & (n == v);
      LE:      pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: condition-gated control signals, flags register and a saved-flags stack for exceptions.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flags_in,
  input  logic [3:0] cond,
  input  logic [1:0] flagw,
  input  logic       instr_valid,
  input  logic       pcs,
  input  logic       regw,
  input  logic       memw,
  input  logic       save,
  input  logic       restore,
  output logic       pcsrc,
  output logic       regwrite,
  output logic       memwrite,
  output logic       cond_ex,
  output logic [3:0] flags_q,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);
  localparam int AW = $clog2(STACK_DEPTH);
  logic [AW:0]   count;
  logic [3:0]    stack [STACK_DEPTH];
  logic [AW-1:0] top;
  logic          pass, push, pop, misuse, wr_nz, wr_cv;
  cond_check u_check (.cond(cond), .flags(flags_q), .pass(pass));
  assign cond_ex     = instr_valid & pass;
  assign pcsrc       = cond_ex & pcs;
  assign regwrite    = cond_ex & regw;
  assign memwrite    = cond_ex & memw;
  assign wr_nz       = cond_ex & flagw[1];
  assign wr_cv       = cond_ex & flagw[0];
  assign stack_empty = count == '0;
  assign stack_full  = count == (AW+1)'(STACK_DEPTH);
  assign push        = save & ~restore & ~stack_full;
  assign pop         = restore & ~save & ~stack_empty;
  assign misuse      = (save & restore) | (save & stack_full) | (restore & stack_empty);
  assign top         = AW'(count - 1'b1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      count     <= '0;
      stack_err <= 1'b0;
    end else begin
      flags_q   <= pop ? stack[top] : {wr_nz ? flags_in[3:2] : flags_q[3:2], wr_cv ? flags_in[1:0] : flags_q[1:0]};
      count     <= push ? count + 1'b1 : pop ? count - 1'b1 : count;
      stack_err <= stack_err | misuse;
    end
  end
  // A push coinciding with reset is harmless: count stays at zero so the entry is dead.
  always_ff @(posedge clk) begin
    if (push) stack[count[AW-1:0]] <= flags_q;
  end
endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter STACK_DEPTH, default 4: depth of the saved-flags stack (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flags_in  input  4  ALU flags {N,Z,C,V}, bit3..bit0.
REQ-005 cond  input  4  instruction condition field, ARM encoding.
REQ-006 flagw  input  2  flag write enables: bit1 updates N,Z; bit0 updates C,V.
REQ-007 instr_valid  input  1  qualifies cond, flagw, pcs, regw and memw this cycle.
REQ-008 pcs, regw, memw  input  1 each  unqualified branch, register-write and memory-write requests.
REQ-009 save  input  1  push the current flags onto the stack (exception entry).
REQ-010 restore  input  1  pop the stack into the flags register (exception return).
REQ-011 pcsrc, regwrite, memwrite  output  1 each  condition-gated requests.
REQ-012 cond_ex  output  1  condition passed and instr_valid is high.
REQ-013 flags_q  output  4  registered {N,Z,C,V}.
REQ-014 stack_full, stack_empty  output  1 each  stack occupancy status.
REQ-015 stack_err  output  1  sticky stack misuse error.

Function
REQ-016 The unit SHALL evaluate cond combinationally against flags_q, not flags_in.
REQ-017 Condition codes SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F 1.
REQ-018 cond_ex SHALL equal instr_valid AND the condition result; pcsrc, regwrite and memwrite SHALL each equal cond_ex AND pcs, regw or memw respectively.
REQ-019 When cond_ex is high and flagw[1] is high, N and Z SHALL load from flags_in at the next edge; flagw[0] SHALL do the same for C and V, with each group independent.
REQ-020 A failed condition SHALL leave flags_q unchanged whatever flagw is.
REQ-021 Flag updates SHALL be visible to cond in the following cycle (latency 1, no bypass).
REQ-022 When save is high, restore is low and the stack is not full, flags_q SHALL be pushed at the edge. The push value is the pre-update flags_q, even if a flag write occurs in the same cycle.
REQ-023 When restore is high, save is low and the stack is not empty, the top entry SHALL be popped into flags_q at the edge. A restore overrides any same-cycle flag write.
REQ-024 A save while full, or a restore while empty, SHALL leave the stack and flags_q unchanged by that request and SHALL set stack_err.
REQ-025 When save and restore are high together, the stack SHALL NOT change, stack_err SHALL be set, and any flag write SHALL still proceed.
REQ-026 stack_err SHALL stay high until reset.
REQ-027 Occupancy SHALL be held in a counter 0..STACK_DEPTH. stack_empty SHALL be high at count 0 and stack_full high at count STACK_DEPTH.

Reset
REQ-028 While reset is high: flags_q = 4'b0000, count = 0, stack_err = 0, stack_empty = 1, stack_full = 0. Stack contents SHALL NOT be reset.
REQ-029 Reset SHALL take effect asynchronously, abandoning any in-flight push or pop.

Structure
REQ-030 A shared package SHALL hold the condition-code enum (EQ..AL, NV) and the flag bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
REQ-031 Condition evaluation SHALL be a combinational sub-module, cond_check (inputs cond and flags, output pass). The stack and flags register SHALL be in cond_unit.

Verification
REQ-032 Directed scenario, split flag write: reset, then flags_in=1111 with flagw=10 and cond=E. Next cycle flags_q=1100; then flagw=01 with flags_in=0011 gives flags_q=1111.
REQ-033 Directed scenario, all 16 condition codes: for every flags_q value, sweep cond=0..F with regw=1. regwrite SHALL match the REQ-017 table in all 256 cases.
REQ-034 Directed scenario, failed condition: flags_q=0000, cond=0 (EQ), flagw=11, flags_in=0100, memw=1. Result SHALL be memwrite=0, cond_ex=0, flags_q still 0000.
REQ-035 Directed scenario, fill and overflow: save 4 times with distinct flags, so stack_full=1. A 5th save SHALL set stack_err=1 and leave count at 4. Four restores SHALL return the flags in LIFO order, ending with stack_empty=1.
REQ-036 Directed scenario, restore priority and underflow: push 1010, then restore alongside flagw=11 and flags_in=0101 gives flags_q=1010. A further restore SHALL set stack_err with flags_q unchanged.
REQ-037 Directed scenario, asynchronous reset: assert reset mid-cycle while save is high. flags_q=0, stack_empty=1 and stack_err=0 SHALL hold before the next clock edge.
